spi_master_ctrl: RTL and testbench

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_master_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// SPI master (CPOL=0, MSB first): shifts one WIDTH-bit frame out on mosi and in from miso,
// then waits for the receiver's status flags and reports done or an error code.
module spi_master_ctrl #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             miso,
  input  logic             sipo_done,
  input  logic             sipo_under,
  input  logic             sipo_over,
  output logic             spi_clk,
  output logic             latch,
  output logic             mosi,
  output logic             busy,
  output logic [WIDTH-1:0] rx_data,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam int BW = $clog2(WIDTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  localparam logic [1:0] EC_NONE    = 2'b00;
  localparam logic [1:0] EC_UNDER   = 2'b01;
  localparam logic [1:0] EC_OVER    = 2'b10;
  localparam logic [1:0] EC_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_WAIT, S_ERROR
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] tx_sr, tx_sr_nx;
  logic [WIDTH-1:0] rx_sr, rx_sr_nx;
  logic [DW-1:0]    div_cnt, div_cnt_nx;
  logic [BW-1:0]    bit_cnt, bit_cnt_nx;
  logic [TW-1:0]    to_cnt, to_cnt_nx;
  logic             spi_clk_nx, latch_nx, mosi_nx, busy_nx, done_nx, err_nx;
  logic [WIDTH-1:0] rx_data_nx;
  logic [1:0]       err_code_nx;

  // Every output is a register; this block computes the value each will take next cycle.
  always_comb begin
    state_nx    = state;
    tx_sr_nx    = tx_sr;
    rx_sr_nx    = rx_sr;
    div_cnt_nx  = div_cnt;
    bit_cnt_nx  = bit_cnt;
    to_cnt_nx   = to_cnt;
    spi_clk_nx  = spi_clk;
    latch_nx    = latch;
    mosi_nx     = mosi;
    busy_nx     = busy;
    rx_data_nx  = rx_data;
    err_code_nx = err_code;
    done_nx     = 1'b0;
    err_nx      = 1'b0;

    case (state)
      S_IDLE: begin
        latch_nx   = 1'b1;
        spi_clk_nx = 1'b0;
        busy_nx    = 1'b0;
        if (start) begin
          state_nx    = S_SETUP;
          tx_sr_nx    = tx_data;
          rx_sr_nx    = '0;
          div_cnt_nx  = '0;
          bit_cnt_nx  = '0;
          to_cnt_nx   = '0;
          err_code_nx = EC_NONE;
          busy_nx     = 1'b1;
          latch_nx    = 1'b0;
          mosi_nx     = tx_data[WIDTH-1];
        end
      end

      S_SETUP: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_nx = '0;
          state_nx   = S_SHIFT;
        end else begin
          div_cnt_nx = div_cnt + DW'(1);
        end
      end

      // Rising half samples miso; falling half advances mosi and ends the frame on the last bit.
      S_SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_nx = '0;
          if (!spi_clk) begin
            spi_clk_nx = 1'b1;
            rx_sr_nx   = {rx_sr[WIDTH-2:0], miso};
          end else begin
            spi_clk_nx = 1'b0;
            tx_sr_nx   = {tx_sr[WIDTH-2:0], 1'b0};
            mosi_nx    = tx_sr[WIDTH-2];
            bit_cnt_nx = bit_cnt + BW'(1);
            if (bit_cnt == BIT_LAST) begin
              state_nx   = S_HOLD;
              rx_data_nx = rx_sr;
            end
          end
        end else begin
          div_cnt_nx = div_cnt + DW'(1);
        end
      end

      S_HOLD: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_nx = '0;
          to_cnt_nx  = '0;
          latch_nx   = 1'b1;
          state_nx   = S_WAIT;
        end else begin
          div_cnt_nx = div_cnt + DW'(1);
        end
      end

      // Underflow outranks overflow, which outranks a successful frame report.
      S_WAIT: begin
        if (sipo_under) begin
          err_code_nx = EC_UNDER;
          err_nx      = 1'b1;
          state_nx    = S_ERROR;
        end else if (sipo_over) begin
          err_code_nx = EC_OVER;
          err_nx      = 1'b1;
          state_nx    = S_ERROR;
        end else if (sipo_done) begin
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          state_nx = S_IDLE;
        end else if (to_cnt == TO_LAST) begin
          err_code_nx = EC_TIMEOUT;
          err_nx      = 1'b1;
          state_nx    = S_ERROR;
        end else begin
          to_cnt_nx = to_cnt + TW'(1);
        end
      end

      S_ERROR: begin
        busy_nx  = 1'b0;
        state_nx = S_IDLE;
      end

      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tx_sr    <= '0;
      rx_sr    <= '0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      to_cnt   <= '0;
      spi_clk  <= 1'b0;
      latch    <= 1'b1;
      mosi     <= 1'b0;
      busy     <= 1'b0;
      rx_data  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= EC_NONE;
    end else begin
      state    <= state_nx;
      tx_sr    <= tx_sr_nx;
      rx_sr    <= rx_sr_nx;
      div_cnt  <= div_cnt_nx;
      bit_cnt  <= bit_cnt_nx;
      to_cnt   <= to_cnt_nx;
      spi_clk  <= spi_clk_nx;
      latch    <= latch_nx;
      mosi     <= mosi_nx;
      busy     <= busy_nx;
      rx_data  <= rx_data_nx;
      done     <= done_nx;
      err      <= err_nx;
      err_code <= err_code_nx;
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: miso is mosi (optionally inverted), expected
// frame results are queued at start and compared when done/err pulses.
module tb_spi_master_ctrl;
  localparam int WIDTH   = 8;
  localparam int CLK_DIV = 2;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] tx_data = '0;
  logic             miso;
  logic             sipo_done = 1'b0;
  logic             sipo_under = 1'b0;
  logic             sipo_over = 1'b0;
  logic             spi_clk, latch, mosi, busy, done, err;
  logic [WIDTH-1:0] rx_data;
  logic [1:0]       err_code;
  logic             invert = 1'b0;

  typedef struct {
    logic [WIDTH-1:0] tx;
    logic [WIDTH-1:0] rx;
    logic [1:0]       code;
    logic             ok;
  } exp_t;

  exp_t             sb_q[$];
  int               checks = 0;
  int               passes = 0;
  int               rise_cnt = 0;
  logic [WIDTH-1:0] mosi_seen = '0;
  logic [WIDTH-1:0] bb_tx [3] = '{8'h5A, 8'hC3, 8'h0F};

  spi_master_ctrl #(.WIDTH(WIDTH), .CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data), .miso(miso),
    .sipo_done(sipo_done), .sipo_under(sipo_under), .sipo_over(sipo_over),
    .spi_clk(spi_clk), .latch(latch), .mosi(mosi), .busy(busy), .rx_data(rx_data),
    .done(done), .err(err), .err_code(err_code)
  );

  assign miso = mosi ^ invert;

  always #5 clk = ~clk;

  // Independent record of what the slave sees: one mosi bit per spi_clk rising edge.
  always @(posedge spi_clk) begin
    rise_cnt  = rise_cnt + 1;
    mosi_seen = {mosi_seen[WIDTH-2:0], mosi};
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // mode: 0 done, 1 under+over, 2 over, 3 no flags (timeout), 4 under
  task automatic applyStimulus(input logic [WIDTH-1:0] tx, input logic inv, input int mode,
                               input logic interfere);
    exp_t e;
    int   base, n, c;
    logic intf, got;
    @(negedge clk);
    invert  = inv;
    tx_data = tx;
    start   = 1'b1;
    e.tx    = tx;
    e.rx    = inv ? ~tx : tx;
    e.ok    = (mode == 0);
    case (mode)
      1, 4:    e.code = 2'b01;
      2:       e.code = 2'b10;
      3:       e.code = 2'b11;
      default: e.code = 2'b00;
    endcase
    sb_q.push_back(e);
    base = rise_cnt;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    checkOutput("latch_low_setup", latch, 0);
    checkOutput("mosi_setup_msb", mosi, tx[WIDTH-1]);
    checkOutput("err_code_cleared", err_code, 0);

    n = 0;
    intf = 1'b0;
    while (latch !== 1'b1 && n < 200) begin
      if (interfere && !intf && (rise_cnt - base) == 3) begin
        start   = 1'b1;
        tx_data = 8'hFF;
        intf    = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (n >= 200) checkOutput("latch_rise_seen", 0, 1);
    checkOutput("spi_clk_rises", rise_cnt - base, WIDTH);
    checkOutput("mosi_sequence", mosi_seen, tx);
    checkOutput("spi_clk_idle_low", spi_clk, 0);

    c = 0;
    got = 1'b0;
    while (!got && c < TIMEOUT + 20) begin
      if (c == 2) begin
        sipo_done  = (mode == 0);
        sipo_under = (mode == 1) || (mode == 4);
        sipo_over  = (mode == 1) || (mode == 2);
      end
      @(negedge clk);
      c++;
      if (done || err) got = 1'b1;
    end
    if (!got) checkOutput("status_pulse_seen", 0, 1);
    sipo_done  = 1'b0;
    sipo_under = 1'b0;
    sipo_over  = 1'b0;
    if (sb_q.size() > 0) e = sb_q.pop_front();
    checkOutput("done_pulse", done, e.ok);
    checkOutput("err_pulse", err, !e.ok);
    checkOutput("rx_data", rx_data, e.rx);
    checkOutput("err_code", err_code, e.code);
    if (mode == 3) checkOutput("timeout_cycles", c, TIMEOUT);

    n = rise_cnt;
    @(negedge clk);
    checkOutput("pulse_one_cycle", {done, err}, 2'b00);
    checkOutput("busy_low_after", busy, 0);
    repeat (2 * CLK_DIV + 2) @(negedge clk);
    checkOutput("err_code_held", err_code, e.code);
    checkOutput("no_extra_frame", rise_cnt - n, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   base, n;
    logic seen;
    exp_t e;

    repeat (3) @(negedge clk);
    checkOutput("rst_spi_clk", spi_clk, 0);
    checkOutput("rst_latch", latch, 1);
    checkOutput("rst_mosi", mosi, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done_err", {done, err}, 2'b00);
    checkOutput("rst_err_code", err_code, 0);
    checkOutput("rst_rx_data", rx_data, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] loopback frames and status flag priority");
    applyStimulus(8'hA5, 1'b0, 0, 1'b0);
    applyStimulus(8'hA5, 1'b0, 1, 1'b0);
    applyStimulus(8'h3C, 1'b1, 2, 1'b0);
    applyStimulus(8'hA5, 1'b0, 3, 1'b0);
    applyStimulus(8'h81, 1'b1, 4, 1'b0);
    applyStimulus(8'h00, 1'b0, 0, 1'b0);
    applyStimulus(8'hFF, 1'b1, 0, 1'b0);

    $display("[TB] start during SHIFT is ignored");
    applyStimulus(8'hA5, 1'b0, 0, 1'b1);

    $display("[TB] reset mid-frame");
    @(negedge clk);
    invert  = 1'b0;
    tx_data = 8'hA5;
    start   = 1'b1;
    base    = rise_cnt;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while ((rise_cnt - base) < 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reached_bit4", (rise_cnt - base) >= 4, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_latch", latch, 1);
    checkOutput("abort_spi_clk", spi_clk, 0);
    checkOutput("abort_busy", busy, 0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done || err) seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done || err) seen = 1'b1;
    end
    checkOutput("abort_no_pulse", seen, 0);
    applyStimulus(8'h3C, 1'b0, 0, 1'b0);

    $display("[TB] back-to-back frames with start held");
    base      = rise_cnt;
    sipo_done = 1'b1;
    invert    = 1'b0;
    @(negedge clk);
    tx_data = bb_tx[0];
    start   = 1'b1;
    for (int f = 0; f < 3; f++) begin
      e.tx = bb_tx[f];
      e.rx = bb_tx[f];
      e.code = 2'b00;
      e.ok = 1'b1;
      sb_q.push_back(e);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done && n < 200);
      checkOutput("b2b_done_seen", done, 1);
      if (sb_q.size() > 0) e = sb_q.pop_front();
      checkOutput("b2b_rx", rx_data, e.rx);
      checkOutput("b2b_idle_latch", latch, 1);
      checkOutput("b2b_idle_busy", busy, 0);
      if (f < 2) tx_data = bb_tx[f+1];
      else start = 1'b0;
      @(negedge clk);
      if (f < 2) checkOutput("b2b_one_idle_cycle", busy, 1);
    end
    sipo_done = 1'b0;
    repeat (2 * CLK_DIV + 2) @(negedge clk);
    checkOutput("b2b_total_rises", rise_cnt - base, 3 * WIDTH);
    checkOutput("b2b_final_idle", busy, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
